// File: rtl/alu_rs_if.sv
// Operand bus around the ALU reservation station: dispatch in, both CDBs in, issued op out.
// master = dispatcher/CDB side, slave = the reservation station.
interface alu_rs_if #(
  parameter int ROB_W    = 4,
  parameter int OPENUM_W = 6,
  parameter int XLEN     = 32
);
  logic                dispatch_valid;
  logic [OPENUM_W-1:0] dispatch_openum;
  logic [XLEN-1:0]     dispatch_v1;
  logic [XLEN-1:0]     dispatch_v2;
  logic [ROB_W-1:0]    dispatch_q1;
  logic [ROB_W-1:0]    dispatch_q2;
  logic                dispatch_q1_busy;
  logic                dispatch_q2_busy;
  logic [XLEN-1:0]     dispatch_imm;
  logic [XLEN-1:0]     dispatch_pc;
  logic [ROB_W-1:0]    dispatch_rob_id;

  logic                alu_cdb_valid;
  logic [ROB_W-1:0]    alu_cdb_rob_id;
  logic [XLEN-1:0]     alu_cdb_value;
  logic                lsb_cdb_valid;
  logic [ROB_W-1:0]    lsb_cdb_rob_id;
  logic [XLEN-1:0]     lsb_cdb_value;

  logic                rs_full;
  logic                alu_en;
  logic [OPENUM_W-1:0] alu_openum;
  logic [XLEN-1:0]     alu_v1;
  logic [XLEN-1:0]     alu_v2;
  logic [XLEN-1:0]     alu_imm;
  logic [XLEN-1:0]     alu_pc;
  logic [ROB_W-1:0]    alu_rob_id;

  modport master (
    output dispatch_valid, dispatch_openum, dispatch_v1, dispatch_v2,
           dispatch_q1, dispatch_q2, dispatch_q1_busy, dispatch_q2_busy,
           dispatch_imm, dispatch_pc, dispatch_rob_id,
           alu_cdb_valid, alu_cdb_rob_id, alu_cdb_value,
           lsb_cdb_valid, lsb_cdb_rob_id, lsb_cdb_value,
    input  rs_full, alu_en, alu_openum, alu_v1, alu_v2, alu_imm, alu_pc, alu_rob_id
  );

  modport slave (
    input  dispatch_valid, dispatch_openum, dispatch_v1, dispatch_v2,
           dispatch_q1, dispatch_q2, dispatch_q1_busy, dispatch_q2_busy,
           dispatch_imm, dispatch_pc, dispatch_rob_id,
           alu_cdb_valid, alu_cdb_rob_id, alu_cdb_value,
           lsb_cdb_valid, lsb_cdb_rob_id, lsb_cdb_value,
    output rs_full, alu_en, alu_openum, alu_v1, alu_v2, alu_imm, alu_pc, alu_rob_id
  );
endinterface

// File: rtl/alu_rs.sv
// ALU reservation station: holds dispatched ops until both operands are ready,
// snoops ALU/LSB CDBs, and issues the lowest-index ready op each cycle on registered outputs.
module alu_rs #(
  parameter int DEPTH    = 16,
  parameter int ROB_W    = 4,
  parameter int OPENUM_W = 6,
  parameter int XLEN     = 32
) (
  input  logic     clk_in,
  input  logic     rst_in,
  input  logic     rdy_in,
  input  logic     rollback_in,
  alu_rs_if.slave  rs
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [OPENUM_W-1:0] OPENUM_NOP = '0;

  logic [DEPTH-1:0]    busy;
  logic [DEPTH-1:0]    q1_busy;
  logic [DEPTH-1:0]    q2_busy;
  logic [OPENUM_W-1:0] openum [DEPTH];
  logic [XLEN-1:0]     v1     [DEPTH];
  logic [XLEN-1:0]     v2     [DEPTH];
  logic [ROB_W-1:0]    q1     [DEPTH];
  logic [ROB_W-1:0]    q2     [DEPTH];
  logic [XLEN-1:0]     imm    [DEPTH];
  logic [XLEN-1:0]     pc     [DEPTH];
  logic [ROB_W-1:0]    rob_id [DEPTH];

  logic                issue_found;
  logic [IDX_W-1:0]    issue_idx;
  logic                free_found;
  logic [IDX_W-1:0]    free_idx;
  logic [XLEN-1:0]     d_v1;
  logic [XLEN-1:0]     d_v2;
  logic                d_q1_busy;
  logic                d_q2_busy;

  assign rs.rs_full = &busy;

  always_comb begin
    issue_found = 1'b0;
    issue_idx   = '0;
    free_found  = 1'b0;
    free_idx    = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!issue_found && busy[i] && !q1_busy[i] && !q2_busy[i]) begin
        issue_found = 1'b1;
        issue_idx   = IDX_W'(i);
      end
      if (!free_found && !busy[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  // Dispatch bypass: a pending operand whose producer is on a CDB this cycle is stored ready.
  always_comb begin
    d_v1      = rs.dispatch_v1;
    d_q1_busy = rs.dispatch_q1_busy;
    d_v2      = rs.dispatch_v2;
    d_q2_busy = rs.dispatch_q2_busy;
    if (rs.dispatch_q1_busy) begin
      if (rs.alu_cdb_valid && rs.alu_cdb_rob_id == rs.dispatch_q1) begin
        d_v1      = rs.alu_cdb_value;
        d_q1_busy = 1'b0;
      end else if (rs.lsb_cdb_valid && rs.lsb_cdb_rob_id == rs.dispatch_q1) begin
        d_v1      = rs.lsb_cdb_value;
        d_q1_busy = 1'b0;
      end
    end
    if (rs.dispatch_q2_busy) begin
      if (rs.alu_cdb_valid && rs.alu_cdb_rob_id == rs.dispatch_q2) begin
        d_v2      = rs.alu_cdb_value;
        d_q2_busy = 1'b0;
      end else if (rs.lsb_cdb_valid && rs.lsb_cdb_rob_id == rs.dispatch_q2) begin
        d_v2      = rs.lsb_cdb_value;
        d_q2_busy = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      busy          <= '0;
      q1_busy       <= '0;
      q2_busy       <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        openum[i] <= '0;
        v1[i]     <= '0;
        v2[i]     <= '0;
        q1[i]     <= '0;
        q2[i]     <= '0;
        imm[i]    <= '0;
        pc[i]     <= '0;
        rob_id[i] <= '0;
      end
      rs.alu_en     <= 1'b0;
      rs.alu_openum <= OPENUM_NOP;
      rs.alu_v1     <= '0;
      rs.alu_v2     <= '0;
      rs.alu_imm    <= '0;
      rs.alu_pc     <= '0;
      rs.alu_rob_id <= '0;
    end else if (rdy_in) begin
      if (rollback_in) begin
        busy          <= '0;
        rs.alu_en     <= 1'b0;
        rs.alu_openum <= OPENUM_NOP;
      end else begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (busy[i] && q1_busy[i]) begin
            if (rs.alu_cdb_valid && rs.alu_cdb_rob_id == q1[i]) begin
              v1[i]      <= rs.alu_cdb_value;
              q1_busy[i] <= 1'b0;
            end else if (rs.lsb_cdb_valid && rs.lsb_cdb_rob_id == q1[i]) begin
              v1[i]      <= rs.lsb_cdb_value;
              q1_busy[i] <= 1'b0;
            end
          end
          if (busy[i] && q2_busy[i]) begin
            if (rs.alu_cdb_valid && rs.alu_cdb_rob_id == q2[i]) begin
              v2[i]      <= rs.alu_cdb_value;
              q2_busy[i] <= 1'b0;
            end else if (rs.lsb_cdb_valid && rs.lsb_cdb_rob_id == q2[i]) begin
              v2[i]      <= rs.lsb_cdb_value;
              q2_busy[i] <= 1'b0;
            end
          end
        end

        if (issue_found) begin
          rs.alu_en         <= 1'b1;
          rs.alu_openum     <= openum[issue_idx];
          rs.alu_v1         <= v1[issue_idx];
          rs.alu_v2         <= v2[issue_idx];
          rs.alu_imm        <= imm[issue_idx];
          rs.alu_pc         <= pc[issue_idx];
          rs.alu_rob_id     <= rob_id[issue_idx];
          busy[issue_idx]   <= 1'b0;
        end else begin
          rs.alu_en     <= 1'b0;
          rs.alu_openum <= OPENUM_NOP;
        end

        // The free slot comes from pre-edge state, so it never aliases the entry issuing now.
        if (rs.dispatch_valid && free_found) begin
          busy[free_idx]    <= 1'b1;
          openum[free_idx]  <= rs.dispatch_openum;
          v1[free_idx]      <= d_v1;
          q1[free_idx]      <= rs.dispatch_q1;
          q1_busy[free_idx] <= d_q1_busy;
          v2[free_idx]      <= d_v2;
          q2[free_idx]      <= rs.dispatch_q2;
          q2_busy[free_idx] <= d_q2_busy;
          imm[free_idx]     <= rs.dispatch_imm;
          pc[free_idx]      <= rs.dispatch_pc;
          rob_id[free_idx]  <= rs.dispatch_rob_id;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_rs.sv
// Self-checking bench for alu_rs: a scoreboard queue of expected issues plus
// cycle-exact latency, full, rollback, freeze and reset checks.
module tb_alu_rs;
  localparam logic [5:0] NOP = 6'd0;
  localparam logic [5:0] ADD = 6'd1;
  localparam logic [5:0] SUB = 6'd2;

  typedef struct packed {
    logic [5:0]  op;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [3:0]  rob;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;
  logic rollback = 1'b0;
  logic live = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb[$];

  alu_rs_if #(.ROB_W(4), .OPENUM_W(6), .XLEN(32)) bus ();

  alu_rs #(.DEPTH(16), .ROB_W(4), .OPENUM_W(6), .XLEN(32)) dut (
    .clk_in      (clk),
    .rst_in      (rst),
    .rdy_in      (rdy),
    .rollback_in (rollback),
    .rs          (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // An edge only produces a new issue when rdy was high at that edge.
  always @(posedge clk) live <= rdy;

  always @(negedge clk) begin
    if (!rst && live && bus.alu_en === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_issue", {28'd0, bus.alu_rob_id}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_openum", {26'd0, bus.alu_openum}, {26'd0, e.op});
        check("sb_v1", bus.alu_v1, e.v1);
        check("sb_v2", bus.alu_v2, e.v2);
        check("sb_imm", bus.alu_imm, e.imm);
        check("sb_pc", bus.alu_pc, e.pc);
        check("sb_rob", {28'd0, bus.alu_rob_id}, {28'd0, e.rob});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus.dispatch_valid   = 1'b0;
    bus.dispatch_q1_busy = 1'b0;
    bus.dispatch_q2_busy = 1'b0;
    bus.alu_cdb_valid    = 1'b0;
    bus.lsb_cdb_valid    = 1'b0;
    rollback             = 1'b0;
  endtask

  task automatic disp(input logic [5:0] op, input logic [31:0] v1, input logic [3:0] q1,
                      input logic q1b, input logic [31:0] v2, input logic [3:0] q2,
                      input logic q2b, input logic [31:0] imm, input logic [31:0] pc,
                      input logic [3:0] rob);
    bus.dispatch_valid   = 1'b1;
    bus.dispatch_openum  = op;
    bus.dispatch_v1      = v1;
    bus.dispatch_q1      = q1;
    bus.dispatch_q1_busy = q1b;
    bus.dispatch_v2      = v2;
    bus.dispatch_q2      = q2;
    bus.dispatch_q2_busy = q2b;
    bus.dispatch_imm     = imm;
    bus.dispatch_pc      = pc;
    bus.dispatch_rob_id  = rob;
  endtask

  task automatic push(input logic [5:0] op, input logic [31:0] v1, input logic [31:0] v2,
                      input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] rob);
    exp_t e;
    e = '{op: op, v1: v1, v2: v2, imm: imm, pc: pc, rob: rob};
    sb.push_back(e);
  endtask

  task automatic alu_cdb(input logic [3:0] tag, input logic [31:0] val);
    bus.alu_cdb_valid  = 1'b1;
    bus.alu_cdb_rob_id = tag;
    bus.alu_cdb_value  = val;
  endtask

  task automatic lsb_cdb(input logic [3:0] tag, input logic [31:0] val);
    bus.lsb_cdb_valid  = 1'b1;
    bus.lsb_cdb_rob_id = tag;
    bus.lsb_cdb_value  = val;
  endtask

  task automatic expect_idle(input string tag);
    check({tag, "_en"}, {31'd0, bus.alu_en}, 32'd0);
    check({tag, "_op"}, {26'd0, bus.alu_openum}, {26'd0, NOP});
  endtask

  initial begin
    bus.dispatch_openum = '0; bus.dispatch_v1 = '0; bus.dispatch_v2 = '0;
    bus.dispatch_q1 = '0; bus.dispatch_q2 = '0; bus.dispatch_imm = '0;
    bus.dispatch_pc = '0; bus.dispatch_rob_id = '0;
    bus.alu_cdb_rob_id = '0; bus.alu_cdb_value = '0;
    bus.lsb_cdb_rob_id = '0; bus.lsb_cdb_value = '0;
    clr();
    repeat (2) tick();
    check("rst_full", {31'd0, bus.rs_full}, 32'd0);
    expect_idle("rst");
    check("rst_v1", bus.alu_v1, 32'd0);
    check("rst_rob", {28'd0, bus.alu_rob_id}, 32'd0);
    rst = 1'b0;
    tick();

    // 1: ready ADD, issue two cycles after dispatch
    disp(ADD, 32'd5, 4'd0, 1'b0, 32'd7, 4'd0, 1'b0, 32'h100, 32'h1000, 4'd3);
    push(ADD, 32'd5, 32'd7, 32'h100, 32'h1000, 4'd3);
    tick(); clr();
    check("t1_c1_en", {31'd0, bus.alu_en}, 32'd0);
    tick();
    check("t1_c2_en", {31'd0, bus.alu_en}, 32'd1);
    check("t1_c2_rob", {28'd0, bus.alu_rob_id}, 32'd3);
    tick();
    expect_idle("t1_c3");

    // 2: SUB waiting on tag 6, woken by ALU CDB two cycles later
    disp(SUB, 32'hDEAD, 4'd6, 1'b1, 32'd3, 4'd0, 1'b0, 32'h4, 32'h2000, 4'd4);
    push(SUB, 32'h10, 32'd3, 32'h4, 32'h2000, 4'd4);
    tick(); clr();
    tick();
    alu_cdb(4'd6, 32'h10);
    tick(); clr();
    check("t2_c3_en", {31'd0, bus.alu_en}, 32'd0);
    tick();
    check("t2_c4_en", {31'd0, bus.alu_en}, 32'd1);
    check("t2_c4_v1", bus.alu_v1, 32'h10);
    tick();
    expect_idle("t2_after");

    // 2b: both CDBs carry the same tag; the ALU CDB wins
    disp(ADD, 32'd1, 4'd0, 1'b0, 32'hBAD, 4'd5, 1'b1, 32'h8, 32'h2100, 4'd5);
    push(ADD, 32'd1, 32'h22, 32'h8, 32'h2100, 4'd5);
    tick(); clr();
    alu_cdb(4'd5, 32'h22);
    lsb_cdb(4'd5, 32'h33);
    tick(); clr();
    tick();
    check("t2b_en", {31'd0, bus.alu_en}, 32'd1);
    check("t2b_v2", bus.alu_v2, 32'h22);
    tick();

    // 3: dispatch bypass from the LSB CDB in the dispatch cycle
    disp(ADD, 32'd1, 4'd0, 1'b0, 32'hDEAD, 4'd9, 1'b1, 32'hC, 32'h3000, 4'd9);
    lsb_cdb(4'd9, 32'hAB);
    push(ADD, 32'd1, 32'hAB, 32'hC, 32'h3000, 4'd9);
    tick(); clr();
    tick();
    check("t3_en", {31'd0, bus.alu_en}, 32'd1);
    check("t3_v2", bus.alu_v2, 32'hAB);
    tick();
    expect_idle("t3_after");

    // 4: fill all 16 entries, then release them with one broadcast
    for (int i = 0; i < 16; i++) begin
      logic [31:0] iv;
      iv = 32'(i);
      disp(ADD, 32'h0, 4'd1, 1'b1, iv, 4'd0, 1'b0, iv + 32'h40, iv * 4, iv[3:0]);
      push(ADD, 32'h77, iv, iv + 32'h40, iv * 4, iv[3:0]);
      if (i == 15) check("t4_not_full_15", {31'd0, bus.rs_full}, 32'd0);
      tick();
    end
    clr();
    check("t4_full", {31'd0, bus.rs_full}, 32'd1);
    alu_cdb(4'd1, 32'h77);
    disp(SUB, 32'd9, 4'd0, 1'b0, 32'd9, 4'd0, 1'b0, 32'd0, 32'hEEEE, 4'd14);
    tick(); clr();
    check("t4_full_hold", {31'd0, bus.rs_full}, 32'd1);
    check("t4_pre_issue_en", {31'd0, bus.alu_en}, 32'd0);
    for (int k = 0; k < 16; k++) begin
      tick();
      check("t4_seq_en", {31'd0, bus.alu_en}, 32'd1);
      check("t4_seq_rob", {28'd0, bus.alu_rob_id}, 32'(k));
      if (k == 0) check("t4_full_drop", {31'd0, bus.rs_full}, 32'd0);
    end
    tick();
    expect_idle("t4_drained");

    // 5: rollback with 5 busy entries and a same-cycle dispatch
    for (int i = 0; i < 5; i++) begin
      disp(ADD, 32'd0, 4'd2, 1'b1, 32'd0, 4'd0, 1'b0, 32'd0, 32'h5000, 4'(i));
      tick();
    end
    disp(ADD, 32'd1, 4'd0, 1'b0, 32'd2, 4'd0, 1'b0, 32'd0, 32'h5100, 4'd7);
    rollback = 1'b1;
    tick(); clr();
    check("t5_full", {31'd0, bus.rs_full}, 32'd0);
    expect_idle("t5_c1");
    alu_cdb(4'd2, 32'h99);
    tick(); clr();
    repeat (3) tick();
    expect_idle("t5_quiet");

    // 6: freeze with rdy low, then resume
    disp(ADD, 32'hA1, 4'd0, 1'b0, 32'hA2, 4'd0, 1'b0, 32'd0, 32'h6000, 4'd10);
    push(ADD, 32'hA1, 32'hA2, 32'd0, 32'h6000, 4'd10);
    tick();
    disp(ADD, 32'hB1, 4'd0, 1'b0, 32'hB2, 4'd0, 1'b0, 32'd0, 32'h6004, 4'd11);
    push(ADD, 32'hB1, 32'hB2, 32'd0, 32'h6004, 4'd11);
    tick();
    check("t6_a_en", {31'd0, bus.alu_en}, 32'd1);
    rdy = 1'b0;
    disp(SUB, 32'hC1, 4'd0, 1'b0, 32'hC2, 4'd0, 1'b0, 32'd0, 32'h6008, 4'd12);
    alu_cdb(4'd3, 32'h1234);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t6_frz_en", {31'd0, bus.alu_en}, 32'd1);
      check("t6_frz_rob", {28'd0, bus.alu_rob_id}, 32'd10);
    end
    clr();
    rdy = 1'b1;
    tick();
    check("t6_resume_rob", {28'd0, bus.alu_rob_id}, 32'd11);
    check("t6_resume_v1", bus.alu_v1, 32'hB1);
    tick();
    expect_idle("t6_after");

    // async reset mid-issue
    disp(ADD, 32'hD1, 4'd0, 1'b0, 32'hD2, 4'd0, 1'b0, 32'd0, 32'h7000, 4'd13);
    push(ADD, 32'hD1, 32'hD2, 32'd0, 32'h7000, 4'd13);
    tick();
    disp(ADD, 32'hE1, 4'd0, 1'b0, 32'hE2, 4'd0, 1'b0, 32'd0, 32'h7004, 4'd15);
    tick(); clr();
    check("t7_en_before", {31'd0, bus.alu_en}, 32'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t7_rst_en", {31'd0, bus.alu_en}, 32'd0);
    check("t7_rst_full", {31'd0, bus.rs_full}, 32'd0);
    tick();
    rst = 1'b0;
    repeat (3) tick();
    expect_idle("t7_quiet");

    check("sb_drain", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end
endmodule
